// File: rtl/ro_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ro_scan_ctrl
//
// Measurement sequencer that owns one external up/down counter and shares it
// between NUM_RO ring-oscillator pulse sources. For each oscillator in turn it
// clears the counter, gates that oscillator onto the up input and the
// reference pulse onto the down input for WINDOW cycles, lets the last gated
// pulse land, captures the net count and moves on to the next oscillator.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high reset
//   start         begin a scan of oscillators 0..NUM_RO-1 (ignored when busy)
//   cont          sampled at the end of the last step; 1 restarts at sel 0
//   abort         stop the scan and return to IDLE
//   ro_pulse      single-cycle synchronized oscillator edge pulses
//   ref_pulse     single-cycle synchronized reference edge pulse
//   cnt_value     current counter output
//   cnt_reset     counter reset drive
//   cnt_up        counter up_in drive
//   cnt_down      counter down_in drive
//   sel           oscillator currently being measured
//   busy          high in every state except IDLE
//   result        captured count
//   result_sel    oscillator index of result
//   result_valid  one-cycle pulse, result/result_sel valid
//   scan_done     one-cycle pulse after the last oscillator is captured
//   result_ovf    (RO_SCAN_OVF_EN only) captured net count fell outside
//                 0..2^CNT_W-1, valid with result_valid
//
// Optional feature macro: RO_SCAN_OVF_EN
// ---------------------------------------------------------------------------
module ro_scan_ctrl #(
    parameter int NUM_RO = 4,
    parameter int SEL_W  = 2,
    parameter int WINDOW = 255,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [NUM_RO-1:0] ro_pulse,
    input  logic              ref_pulse,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_reset,
    output logic              cnt_up,
    output logic              cnt_down,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic [SEL_W-1:0]  result_sel,
    output logic              result_valid,
    output logic              scan_done
`ifdef RO_SCAN_OVF_EN
    ,
    output logic              result_ovf
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SETTLE,
        CAPTURE,
        NEXT
    } state_t;

    localparam logic [15:0]      WIN_LOAD = 16'(WINDOW - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_RO - 1);

    state_t      state;
    logic [15:0] timer;   // COUNT window, then reused for the 2-cycle SETTLE
    logic        ro_sel;

    assign ro_sel = ro_pulse[sel];

    // NOTE: every register here is sequential state, so all assignments are
    // non-blocking; blocking writes would let later statements see the new
    // value within the same edge and break the registered-output timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            cnt_reset    <= 1'b0;
            cnt_up       <= 1'b0;
            cnt_down     <= 1'b0;
            sel          <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_sel   <= '0;
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle, so each branch
            // below only has to name the single cycle in which it fires.
            cnt_reset    <= 1'b0;
            result_valid <= 1'b0;
            scan_done    <= 1'b0;

            if (abort && state != IDLE) begin
                // sel and result deliberately hold for post-mortem readout
                state    <= IDLE;
                busy     <= 1'b0;
                cnt_up   <= 1'b0;
                cnt_down <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state     <= CLEAR;
                            sel       <= '0;
                            busy      <= 1'b1;
                            cnt_reset <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        timer    <= WIN_LOAD;
                        cnt_up   <= 1'b0;
                        cnt_down <= 1'b0;
                        state    <= COUNT;
                    end
                    COUNT: begin
                        // Coincident edges cancel so the counter never sees
                        // both drives at once.
                        cnt_up   <= ro_sel & ~ref_pulse;
                        cnt_down <= ref_pulse & ~ro_sel;
                        if (timer == '0) begin
                            timer <= 16'd1;
                            state <= SETTLE;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    SETTLE: begin
                        cnt_up   <= 1'b0;
                        cnt_down <= 1'b0;
                        if (timer == '0) begin
                            state <= CAPTURE;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    CAPTURE: begin
                        result       <= cnt_value;
                        result_sel   <= sel;
                        result_valid <= 1'b1;
                        state        <= NEXT;
                    end
                    NEXT: begin
                        if (sel != SEL_LAST) begin
                            sel       <= sel + SEL_W'(1);
                            cnt_reset <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            scan_done <= 1'b1;
                            if (cont) begin
                                sel       <= '0;
                                cnt_reset <= 1'b1;
                                state     <= CLEAR;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RO_SCAN_OVF_EN
    // Two's-complement shadow of the net count, two bits wider than the
    // counter so that wrap-around in the real counter remains detectable.
    logic [CNT_W+1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow     <= '0;
            result_ovf <= 1'b0;
        end else begin
            // Follows the same registered drives the counter sees.
            if (state == CLEAR) begin
                shadow <= '0;
            end else if (cnt_up) begin
                shadow <= shadow + (CNT_W + 2)'(1);
            end else if (cnt_down) begin
                shadow <= shadow - (CNT_W + 2)'(1);
            end

            // Negative (sign bit) or >= 2^CNT_W (next bit up while positive).
            if (state == CAPTURE && !abort) begin
                result_ovf <= shadow[CNT_W+1] | shadow[CNT_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ro_scan_ctrl with NUM_RO=4, WINDOW=16, CNT_W=8 and an
// attached up/down counter model. Each table record describes the pulse
// pattern applied during one scan step and the hand-computed capture value.
// ---------------------------------------------------------------------------
module tb_ro_scan_ctrl;

    localparam int NUM_RO = 4;
    localparam int SEL_W  = 2;
    localparam int WINDOW = 16;
    localparam int CNT_W  = 8;
    localparam int STEP   = WINDOW + 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cont;
    logic              abort;
    logic [NUM_RO-1:0] ro_pulse;
    logic              ref_pulse;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_reset;
    logic              cnt_up;
    logic              cnt_down;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic [SEL_W-1:0]  result_sel;
    logic              result_valid;
    logic              scan_done;
`ifdef RO_SCAN_OVF_EN
    logic              result_ovf;
`endif

    ro_scan_ctrl #(
        .NUM_RO(NUM_RO),
        .SEL_W (SEL_W),
        .WINDOW(WINDOW),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cont        (cont),
        .abort       (abort),
        .ro_pulse    (ro_pulse),
        .ref_pulse   (ref_pulse),
        .cnt_value   (cnt_value),
        .cnt_reset   (cnt_reset),
        .cnt_up      (cnt_up),
        .cnt_down    (cnt_down),
        .sel         (sel),
        .busy        (busy),
        .result      (result),
        .result_sel  (result_sel),
        .result_valid(result_valid),
        .scan_done   (scan_done)
`ifdef RO_SCAN_OVF_EN
        ,
        .result_ovf  (result_ovf)
`endif
    );

    always #5 clk = ~clk;

    // External counter the controller drives.
    always @(posedge clk) begin
        if (reset || cnt_reset)  cnt_value <= '0;
        else if (cnt_up)         cnt_value <= cnt_value + 8'd1;
        else if (cnt_down)       cnt_value <= cnt_value - 8'd1;
    end

    // One scan step: ro_en bits pulse during the first ro_n COUNT cycles,
    // ref_pulse during the first ref_n COUNT cycles.
    typedef struct {
        logic [NUM_RO-1:0] ro_en;
        int                ro_n;
        int                ref_n;
        logic [CNT_W-1:0]  exp_result;
        logic              exp_ovf;
    } step_vec_t;

    step_vec_t vecs[8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected counter drive in step cycle c (c=0 is CLEAR, COUNT is c=1..16,
    // its gated pulses appear one cycle later at c=2..17).
    function automatic logic exp_drive(input int vi, input int s, input int c, input bit up);
        int   k;
        logic r;
        logic f;
        if (c < 2 || c > WINDOW + 1) return 1'b0;
        k = c - 2;
        r = (k < vecs[vi].ro_n) && vecs[vi].ro_en[s];
        f = (k < vecs[vi].ref_n);
        return up ? (r && !f) : (f && !r);
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cnt_reset"},    cnt_reset,    0);
        check({tag, " cnt_up"},       cnt_up,       0);
        check({tag, " cnt_down"},     cnt_down,     0);
        check({tag, " sel"},          sel,          0);
        check({tag, " busy"},         busy,         0);
        check({tag, " result"},       result,       0);
        check({tag, " result_sel"},   result_sel,   0);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " scan_done"},    scan_done,    0);
`ifdef RO_SCAN_OVF_EN
        check({tag, " result_ovf"},   result_ovf,   0);
`endif
    endtask

    // Runs one step, entered #1 after the edge that moves the DUT into CLEAR.
    // start_at: cycle in which start is pulsed (no effect expected).
    // cut_at:   cycle in which reset (cut_reset=1) or abort is asserted; the
    //           step ends right after that edge.
    task automatic run_step(input int vi, input int s, input bit cont_in, input bit done0,
                            input int start_at, input int cut_at, input bit cut_reset);
        for (int c = 0; c < STEP; c++) begin
            string tag;
            int    k;
            tag = $sformatf("v%0d s%0d c%0d", vi, s, c);
            check({tag, " busy"},         busy,         1);
            check({tag, " sel"},          sel,          s);
            check({tag, " cnt_reset"},    cnt_reset,    (c == 0));
            check({tag, " cnt_up"},       cnt_up,       exp_drive(vi, s, c, 1'b1));
            check({tag, " cnt_down"},     cnt_down,     exp_drive(vi, s, c, 1'b0));
            check({tag, " result_valid"}, result_valid, (c == STEP - 1));
            check({tag, " scan_done"},    scan_done,    (c == 0 && done0));
            if (c == STEP - 1) begin
                check({tag, " result"},     result,     vecs[vi].exp_result);
                check({tag, " result_sel"}, result_sel, s);
`ifdef RO_SCAN_OVF_EN
                check({tag, " result_ovf"}, result_ovf, vecs[vi].exp_ovf);
`endif
            end

            ro_pulse  = '0;
            ref_pulse = 1'b0;
            cont      = 1'b0;
            if (c >= 1 && c <= WINDOW) begin
                k = c - 1;
                if (k < vecs[vi].ro_n) ro_pulse = vecs[vi].ro_en;
                ref_pulse = (k < vecs[vi].ref_n);
            end
            if (c == STEP - 1) cont = cont_in;
            if (c == start_at) start = 1'b1;
            if (c == cut_at) begin
                if (cut_reset) reset = 1'b1;
                else           abort = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
            abort = 1'b0;
            if (c == cut_at) break;
        end
        ro_pulse  = '0;
        ref_pulse = 1'b0;
        cont      = 1'b0;
    endtask

    initial begin
        // Scan A
        vecs[0] = '{4'b0001, 16, 0,  8'd16,  1'b0};  // steady ro[0]
        vecs[1] = '{4'b0001, 16, 0,  8'd0,   1'b0};  // unselected bit ignored
        vecs[2] = '{4'b0100, 16, 16, 8'd0,   1'b0};  // coincident pulses cancel
        vecs[3] = '{4'b0000, 0,  10, 8'd246, 1'b1};  // net -10 wraps
        // Scan B
        vecs[4] = '{4'b1111, 5,  2,  8'd3,   1'b0};
        vecs[5] = '{4'b0010, 16, 6,  8'd10,  1'b0};
        vecs[6] = '{4'b0100, 3,  0,  8'd3,   1'b0};
        vecs[7] = '{4'b1000, 4,  9,  8'd251, 1'b1};  // net -5 wraps

        reset     = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        ro_pulse  = '0;
        ref_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Full scan, cont=0: four captures then scan_done and idle.
        do_start();
        for (int s = 0; s < NUM_RO; s++) run_step(s, s, 1'b0, 1'b0, -1, -1, 1'b0);
        check("scanA done",       scan_done,    1);
        check("scanA busy",       busy,         0);
        check("scanA valid",      result_valid, 0);
        check("scanA cnt_reset",  cnt_reset,    0);
        check("scanA sel hold",   sel,          3);
        @(posedge clk); #1;
        check("scanA done pulse", scan_done,    0);
        check("scanA idle",       busy,         0);

        // Full scan, cont=1: wraps straight into sel 0 with busy held.
        do_start();
        for (int s = 0; s < NUM_RO; s++)
            run_step(4 + s, s, (s == NUM_RO - 1), 1'b0, -1, -1, 1'b0);
        // Restarted step 0, with start pressed while busy.
        run_step(4, 0, 1'b0, 1'b1, 5, -1, 1'b0);
        // Step 1 aborted in COUNT cycle 5.
        run_step(5, 1, 1'b0, 1'b0, -1, 6, 1'b0);
        check("abort busy",       busy,         0);
        check("abort cnt_up",     cnt_up,       0);
        check("abort cnt_down",   cnt_down,     0);
        check("abort cnt_reset",  cnt_reset,    0);
        check("abort valid",      result_valid, 0);
        check("abort done",       scan_done,    0);
        check("abort sel hold",   sel,          1);
        check("abort result",     result,       3);
        check("abort result_sel", result_sel,   0);
        for (int i = 0; i < STEP; i++) begin
            @(posedge clk); #1;
            check($sformatf("post-abort valid %0d", i), result_valid, 0);
            check($sformatf("post-abort busy %0d", i),  busy,         0);
        end

        // Reset during the first SETTLE cycle, then a clean scan from sel 0.
        do_start();
        run_step(0, 0, 1'b0, 1'b0, -1, WINDOW + 1, 1'b1);
        check_all_zero("mid-settle reset");
        do_start();
        for (int s = 0; s < NUM_RO; s++) run_step(s, s, 1'b0, 1'b0, -1, -1, 1'b0);
        check("rescan done", scan_done, 1);
        check("rescan busy", busy,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
